req_grant_arbiter: RTL
======================

// Module: req_grant_arbiter
// PURPOSE
//  Shares one resource (bus/port) among 4 requesters using the 4-bit priority
//  encoding rule: the highest-index active request wins. Adds grant locking,
//  a bounded hold time and a one-shot fairness mask, so a high-index requester
//  cannot starve lower ones. Sits between the requesters and the shared datapath.
// PARAMETERS
//  MAX_HOLD  8  max consecutive grant cycles per grant (legal range 2..256)
//  HOLD_W    8  hold counter width; must satisfy 2**HOLD_W >= MAX_HOLD
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  req        in   4  request lines; bit i = requester i, level-sensitive
//  gnt        out  4  one-hot grant, registered; all-zero when idle
//  gnt_id     out  2  binary index of granted requester (valid when gnt_valid)
//  gnt_valid  out  1  high while any grant is held (= |gnt)
//  timeout    out  1  one-cycle pulse: previous grant was force-released
// BEHAVIOUR
//  - Reset (async, rst_n=0): gnt=0, gnt_id=0, gnt_valid=0, timeout=0,
//    state=IDLE, mask=0, hold_cnt=0. Takes effect immediately, also mid-grant.
//  - FSM with states IDLE and GRANT. All outputs are registered.
//  - IDLE: elig = req & ~mask; if elig==0 then elig = req (mask ignored).
//    If elig!=0 at the clock edge: grant the highest set bit of elig, then
//    -> GRANT, hold_cnt=0, mask=0. Else stay in IDLE with gnt=0.
//    Latency: req sampled at edge k -> gnt high from edge k (visible cycle k+1).
//  - GRANT: hold_cnt increments every cycle; no preemption by any other req.
//    * req[gnt_id]==0 at edge -> IDLE, gnt=0 (normal release, mask unchanged).
//    * else if hold_cnt==MAX_HOLD-1 -> IDLE, gnt=0, mask[gnt_id]=1,
//      timeout=1 for that one IDLE cycle (grant lasted exactly MAX_HOLD cycles).
//    * else stay in GRANT.
//  - Every grant is followed by at least one IDLE cycle with gnt=0, so
//    back-to-back grants are separated by exactly one idle cycle when requests are pending.
//  - Mask: set only on timeout, cleared at the next grant issue. A timed-out
//    requester therefore loses exactly one arbitration, and only when another
//    requester is pending; if it is the sole requester it is regranted.
//  - req[i] dropping for a non-granted i has no effect; glitches in req during
//    GRANT are ignored except on bit gnt_id.
//  - hold_cnt does not wrap: it only counts up to MAX_HOLD-1 in GRANT.
//  - gnt is always one-hot or zero. gnt_id holds its last value when idle.
// TESTING
//  1 req=0010 for 3 cycles then 0000 -> gnt=0010, gnt_id=1 for 3 cycles,
//    then gnt=0 the cycle after req drop is sampled; timeout never set.
//  2 req=1011 at the same edge -> gnt=1000, gnt_id=3; after req[3] drops:
//    1 idle cycle, then gnt=0010.
//  3 MAX_HOLD=8, req=1001 held -> gnt=1000 for 8 cycles, then 1 idle cycle with
//    timeout=1, then gnt=0001; when req[0] drops -> idle, then gnt=1000 again.
//  4 req=0100 held only -> gnt=0100 for 8 cycles, idle+timeout pulse,
//    then gnt=0100 again (mask ignored, sole requester).
//  5 req=0001 granted, req[3] rises mid-grant -> gnt stays 0001 until req[0]
//    drops or the hold limit is reached; then 1 idle cycle, then gnt=1000.
//  6 rst_n low mid-grant (between edges) -> gnt=0, gnt_valid=0 immediately;
//    after release with req=0100 held -> first grant 0100 at next edge.

Source files
------------

// File: rtl/req_grant_arbiter.sv
// Four-requester arbiter: highest-index request wins, grants are locked until
// release or hold-limit timeout, and a timed-out requester sits out one round.
module req_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N    = 4;
  localparam int unsigned ID_W = 2;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [N-1:0]      mask;
  logic [HOLD_W-1:0] hold_cnt;

  logic [N-1:0]      elig_c;
  logic [ID_W-1:0]   pick_c;
  logic              pick_valid_c;

  // Eligible set with the one-shot fairness mask; mask is dropped if it empties the set.
  always_comb begin
    elig_c = req & ~mask;
    if (elig_c == '0) begin
      elig_c = req;
    end
    pick_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (elig_c[i]) begin
        pick_c = ID_W'(i);
      end
    end
    pick_valid_c = |elig_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      mask      <= '0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid_c) begin
            state     <= GRANT;
            gnt       <= N'(1) << pick_c;
            gnt_id    <= pick_c;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
            mask      <= '0;
          end
        end
        GRANT: begin
          if (!req[gnt_id]) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
          end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
            // Hold limit reached: force release and bench this requester for one round.
            state        <= IDLE;
            gnt          <= '0;
            gnt_valid    <= 1'b0;
            mask[gnt_id] <= 1'b1;
            timeout      <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
